axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter BURST_LEN_MAX, default 16, meaning the maximum beats per burst accepted without error.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have the AXI read address channel: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arlock in 2, arcache in 4, arprot in 3, arvalid in 1, arready out 1.
REQ-005 SHALL have the AXI read data channel: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 SHALL have the AXI write address channel: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot and awvalid as inputs with widths matching the read address channel; awready out 1.
REQ-007 SHALL have the AXI write data channel: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-008 SHALL have the AXI write response channel: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-009 SHALL have the SRAM port: sram_en out 1; sram_write_en out 4 (byte enables); sram_addr out 32 (word-aligned); sram_write_data out 32; sram_read_data in 32 (valid exactly 1 cycle after an sram_en read).

Function
REQ-010 SHALL implement the FSM states IDLE, RD_REQ, RD_DATA, WR_DATA and WR_RESP.
REQ-011 SHALL assert arready and awready only in IDLE, combinationally, and only for the channel granted.
REQ-012 SHALL grant by alternating priority when arvalid and awvalid are both high in IDLE (read first after reset, toggling on each contended grant), and otherwise grant whichever channel is valid.
REQ-013 SHALL capture id, addr, len, size and burst on the handshake, clear the beat counter, and go to RD_REQ (read) or WR_DATA (write).
REQ-014 SHALL in RD_REQ drive sram_en=1 and sram_write_en=0 for one cycle at {addr[31:2],2'b00}, then go to RD_DATA.
REQ-015 SHALL in RD_DATA hold rvalid=1 with rdata registered from sram_read_data, rid=captured id and rlast=(beat==len), all stable until rready.
REQ-016 SHALL on the RD_DATA handshake return to IDLE if rlast is set; otherwise it SHALL advance addr and beat and go to RD_REQ, giving 2 cycles per beat.
REQ-017 SHALL in WR_DATA drive wready=1 and, on each cycle with wvalid=1, combinationally drive sram_en=1, sram_write_en=wstrb, sram_write_data=wdata and sram_addr=current word address, then advance addr and beat.
REQ-018 SHALL leave WR_DATA for WR_RESP on the handshake with wlast=1, and SHALL also leave on the handshake where beat==len even if wlast=0; wid SHALL be ignored.
REQ-019 SHALL in WR_RESP hold bvalid=1 with bid=captured awid and bresp as decided in REQ-021/022, returning to IDLE on bready.
REQ-020 SHALL compute the next address as follows: FIXED (00) keeps addr; INCR (01) uses addr+(1<<size); WRAP (10) keeps the bits above log2((len+1)<<size) and wraps the lower bits.
REQ-021 SHALL treat burst=11, size>2, len+1>BURST_LEN_MAX, or WRAP with len not in {1,3,7,15} as an error: full beat count still transferred, sram_en=0 for all beats, rdata=0, rresp/bresp=SLVERR (10).
REQ-022 SHALL return OKAY (00) in all non-error cases; lock, cache and prot SHALL be ignored.
REQ-023 SHALL keep every output other than those named in REQ-014 to REQ-019 at 0.

Reset
REQ-024 SHALL on rst=0 at a clock edge enter IDLE; arready, awready, rvalid, wready, bvalid, sram_en and sram_write_en SHALL be 0, and rdata, rid, bid, rresp, bresp SHALL be 0.
REQ-025 SHALL abandon any in-flight burst on reset, with no further SRAM access, and SHALL reset read-first priority.

Structure
REQ-026 SHALL place the burst codes (FIXED/INCR/WRAP), response codes (OKAY/SLVERR) and size codes in the shared bus definitions header, not locally.
REQ-027 SHALL contain one sub-module, axi_burst_addr (combinational next address from addr, size, len and burst), instantiated once.

Verification
REQ-028 SHALL test single read: araddr=0x100, arlen=0, arsize=2, SRAM returns 0xDEADBEEF -> sram_addr=0x100, rdata=0xDEADBEEF, rlast=1, rresp=00, rid=arid.
REQ-029 SHALL test INCR write: awaddr=0x200, awlen=3, size=2, wstrb=F -> SRAM writes at 0x200/204/208/20C, then one bvalid with bresp=00 and bid=awid.
REQ-030 SHALL test WRAP read: araddr=0x38, arlen=3, size=2 -> sram_addr sequence 0x38, 0x3C, 0x30, 0x34.
REQ-031 SHALL test byte write: awaddr=0x403, awsize=0, wstrb=1000 -> sram_addr=0x400, sram_write_en=1000.
REQ-032 SHALL test contention: arvalid and awvalid high together twice after reset -> read granted first, then write; rready held low 5 cycles -> rdata and rvalid stable.
REQ-033 SHALL test error and reset: arburst=11, arlen=1 -> 2 beats rresp=10, sram_en never 1; rst=0 during beat 2 of a 4-beat write -> next cycle IDLE with all valids 0.

Source files
------------

// File: rtl/axi_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_pkg
//   Shared bus definitions for the AXI-to-SRAM slave: burst, response and
//   size codes, the controller state encoding, and the burst legality check.
//   No ports (package).
// ---------------------------------------------------------------------------
package axi_sram_slave_pkg;

   // AXI burst type codes
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // AXI transfer size codes (bytes per beat = 1 << size)
   localparam logic [2:0] SIZE_1B = 3'd0;
   localparam logic [2:0] SIZE_2B = 3'd1;
   localparam logic [2:0] SIZE_4B = 3'd2;

   // Controller states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_DATA = 3'd2,
      WR_DATA = 3'd3,
      WR_RESP = 3'd4
   } state_t;

   // A burst is served with SLVERR (no SRAM traffic) when its type is
   // reserved, its beats are wider than the 32-bit bus, it is longer than
   // the slave accepts, or it is a WRAP whose length is not 2/4/8/16 beats.
   function automatic logic burst_is_err(input logic [1:0]  burst,
                                         input logic [2:0]  size,
                                         input logic [7:0]  len,
                                         input int unsigned max_len);
      logic bad_wrap;
      logic too_long;
      bad_wrap = (burst == BURST_WRAP) &&
                 !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
      too_long = (({24'd0, len} + 32'd1) > max_len);
      return (burst == BURST_RSVD) || (size > SIZE_4B) || too_long || bad_wrap;
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// ---------------------------------------------------------------------------
// axi_burst_addr
//   Combinational next-beat address for an AXI burst.
//   Ports:
//     addr      in  32  current beat address
//     size      in  3   bytes per beat = 1 << size
//     len       in  8   beats in burst minus one
//     burst     in  2   FIXED / INCR / WRAP
//     next_addr out 32  address of the following beat
// ---------------------------------------------------------------------------
module axi_burst_addr
   import axi_sram_slave_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   input  logic [7:0]  len,
   input  logic [1:0]  burst,
   output logic [31:0] next_addr
);

   logic [31:0] step;
   logic [31:0] incr_addr;
   logic [31:0] wrap_mask;

   always_comb begin
      step      = 32'd1 << size;
      incr_addr = addr + step;
      // Total bytes in a wrap burst is (len+1) << size, a power of two for
      // legal wraps; the bits below it wrap, the bits above stay put.
      wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
      next_addr = addr;
      case (burst)
         BURST_INCR: next_addr = incr_addr;
         BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default:    next_addr = addr;
      endcase
   end

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI3-style slave serving one burst at a time from a single-port SRAM
//   with one cycle of read latency.
//   Ports:
//     clk, rst                 clock (rising edge), synchronous active-low reset
//     ar*  / arready           read address channel
//     rid, rdata, rresp, rlast, rvalid / rready   read data channel
//     aw*  / awready           write address channel
//     wid, wdata, wstrb, wlast, wvalid / wready   write data channel
//     bid, bresp, bvalid / bready                 write response channel
//     sram_en, sram_write_en, sram_addr, sram_write_data, sram_read_data
//                              SRAM port (read data valid one cycle after en)
//   Parameter:
//     BURST_LEN_MAX            longest burst (beats) accepted without error
// ---------------------------------------------------------------------------
module axi_sram_slave
   import axi_sram_slave_pkg::*;
#(
   parameter int unsigned BURST_LEN_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   // read address channel
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   // read data channel
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   // write address channel
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   // write data channel
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   // write response channel
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   // SRAM port
   output logic        sram_en,
   output logic [3:0]  sram_write_en,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_write_data,
   input  logic [31:0] sram_read_data
);

   // Handshake rule on every channel: a transfer happens on the rising edge
   // where valid and ready are both 1; the source holds valid and payload
   // stable until then, and ready may depend combinationally on valid.

   state_t      state_q, state_d;
   logic [3:0]  id_q;
   logic [31:0] addr_q;
   logic [7:0]  len_q;
   logic [7:0]  beat_q;
   logic [2:0]  size_q;
   logic [1:0]  burst_q;
   logic        err_q;
   logic        prio_wr_q;     // next contended grant goes to the write side
   logic        rd_first_q;    // first RD_DATA cycle: SRAM data is live
   logic [31:0] rdata_hold_q;  // SRAM data held for rready stalls

   logic [31:0] next_addr;
   logic [31:0] word_addr;
   logic        grant_rd, grant_wr;
   logic        ar_hs, aw_hs, r_hs, w_hs, b_hs;
   logic        last_beat;
   logic        ar_err, aw_err;

   // Sideband fields that this slave deliberately does not act on.
   logic        unused_inputs;
   assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

   axi_burst_addr u_burst_addr (
      .addr      (addr_q),
      .size      (size_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   assign word_addr = {addr_q[31:2], 2'b00};
   assign last_beat = (beat_q == len_q);
   assign ar_err    = burst_is_err(arburst, arsize, arlen, BURST_LEN_MAX);
   assign aw_err    = burst_is_err(awburst, awsize, awlen, BURST_LEN_MAX);

   // Read wins a tie unless the previous tie went to read.
   assign grant_rd = arvalid && !(awvalid && prio_wr_q);
   assign grant_wr = awvalid && !grant_rd;

   assign ar_hs = arvalid && arready;
   assign aw_hs = awvalid && awready;
   assign r_hs  = rvalid  && rready;
   assign w_hs  = wvalid  && wready;
   assign b_hs  = bvalid  && bready;

   // Outputs are forced to zero while reset is held so that an abandoned
   // burst cannot touch the SRAM or complete a handshake.
   always_comb begin
      arready         = 1'b0;
      awready         = 1'b0;
      rid             = 4'd0;
      rdata           = 32'd0;
      rresp           = RESP_OKAY;
      rlast           = 1'b0;
      rvalid          = 1'b0;
      wready          = 1'b0;
      bid             = 4'd0;
      bresp           = RESP_OKAY;
      bvalid          = 1'b0;
      sram_en         = 1'b0;
      sram_write_en   = 4'd0;
      sram_addr       = 32'd0;
      sram_write_data = 32'd0;
      if (rst) begin
         case (state_q)
            IDLE: begin
               arready = grant_rd;
               awready = grant_wr;
            end
            RD_REQ: begin
               if (!err_q) begin
                  sram_en   = 1'b1;
                  sram_addr = word_addr;
               end
            end
            RD_DATA: begin
               rvalid = 1'b1;
               rid    = id_q;
               rlast  = last_beat;
               rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
               if (!err_q) rdata = rd_first_q ? sram_read_data : rdata_hold_q;
            end
            WR_DATA: begin
               wready = 1'b1;
               if (wvalid && !err_q) begin
                  sram_en         = 1'b1;
                  sram_write_en   = wstrb;
                  sram_addr       = word_addr;
                  sram_write_data = wdata;
               end
            end
            WR_RESP: begin
               bvalid = 1'b1;
               bid    = id_q;
               bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ar_hs)      state_d = RD_REQ;
            else if (aw_hs) state_d = WR_DATA;
         end
         RD_REQ:  state_d = RD_DATA;
         RD_DATA: if (r_hs) state_d = last_beat ? IDLE : RD_REQ;
         // The burst ends on wlast or on the counted last beat, whichever
         // comes first, so a master that forgets wlast cannot hang the slave.
         WR_DATA: if (w_hs && (wlast || last_beat)) state_d = WR_RESP;
         WR_RESP: if (b_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         id_q         <= 4'd0;
         addr_q       <= 32'd0;
         len_q        <= 8'd0;
         beat_q       <= 8'd0;
         size_q       <= 3'd0;
         burst_q      <= 2'b00;
         err_q        <= 1'b0;
         prio_wr_q    <= 1'b0;
         rd_first_q   <= 1'b0;
         rdata_hold_q <= 32'd0;
      end else begin
         state_q <= state_d;

         if (state_q == IDLE && arvalid && awvalid) prio_wr_q <= ~prio_wr_q;

         if (ar_hs) begin
            id_q    <= arid;
            addr_q  <= araddr;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
            err_q   <= ar_err;
            beat_q  <= 8'd0;
         end else if (aw_hs) begin
            id_q    <= awid;
            addr_q  <= awaddr;
            len_q   <= awlen;
            size_q  <= awsize;
            burst_q <= awburst;
            err_q   <= aw_err;
            beat_q  <= 8'd0;
         end

         if (state_q == RD_REQ) rd_first_q <= 1'b1;
         if (state_q == RD_DATA && rd_first_q) begin
            rdata_hold_q <= sram_read_data;
            rd_first_q   <= 1'b0;
         end

         if ((r_hs && !last_beat) || w_hs) begin
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Directed scoreboard bench for axi_sram_slave. Drivers push the expected
//   SRAM accesses, read beats and write responses into queues; negedge
//   monitors pop and compare whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;
   import axi_sram_slave_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
   logic [3:0]  arcache, awcache, wstrb;
   logic        arvalid, arready, awvalid, awready;
   logic        rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;
   logic        sram_en;
   logic [3:0]  sram_write_en;
   logic [31:0] sram_addr, sram_write_data, sram_read_data;

   axi_sram_slave #(.BURST_LEN_MAX(16)) dut (
      .clk(clk), .rst(rst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .sram_en(sram_en), .sram_write_en(sram_write_en), .sram_addr(sram_addr),
      .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
   );

   // ---------------- SRAM model (1-cycle read latency) ----------------
   logic [31:0] mem [0:1023];
   logic [31:0] sram_rd_reg = 32'd0;
   assign sram_read_data = sram_rd_reg;

   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_write_en == 4'd0) sram_rd_reg <= mem[sram_addr[11:2]];
         for (int b = 0; b < 4; b++)
            if (sram_write_en[b]) mem[sram_addr[11:2]][8*b +: 8] <= sram_write_data[8*b +: 8];
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fails  = 0;
   logic [67:0] exp_s_q[$];   // {write_en, addr, write_data}
   logic [38:0] exp_r_q[$];   // {rid, rdata, rresp, rlast}
   logic [5:0]  exp_b_q[$];   // {bid, bresp}

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sram_en) begin
         if (exp_s_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL sram_unexpected: got we=%0h addr=%0h data=%0h expected no access",
                     sram_write_en, sram_addr, sram_write_data);
         end else begin
            check("sram_access", {sram_write_en, sram_addr, sram_write_data}, exp_s_q.pop_front());
         end
      end
      if (rvalid && rready) begin
         if (exp_r_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL r_unexpected: got rid=%0h rdata=%0h expected no beat", rid, rdata);
         end else begin
            check("r_beat", {rid, rdata, rresp, rlast}, exp_r_q.pop_front());
         end
      end
      if (bvalid && bready) begin
         if (exp_b_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL b_unexpected: got bid=%0h bresp=%0h expected no response", bid, bresp);
         end else begin
            check("b_resp", {bid, bresp}, exp_b_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_neg(input string name, input int which);
      // which: 0=arready 1=awready 2=wready 3=rvalid
      bit seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         case (which)
            0: seen = arready;
            1: seen = awready;
            2: seen = wready;
            default: seen = rvalid;
         endcase
      end
      if (!seen) begin
         n_checks++;
         n_fails++;
         $display("FAIL %s_timeout: got no handshake expected one within 50 cycles", name);
      end
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      arlock = 2'($urandom_range(0, 3)); arcache = 4'($urandom_range(0, 15));
      arprot = 3'($urandom_range(0, 7));
      arvalid = 1'b1;
      wait_neg("ar", 0);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      awlock = 2'($urandom_range(0, 3)); awcache = 4'($urandom_range(0, 15));
      awprot = 3'($urandom_range(0, 7));
      awvalid = 1'b1;
      wait_neg("aw", 1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
      wdata = data; wstrb = strb; wlast = last; wid = 4'($urandom_range(0, 15));
      wvalid = 1'b1;
      wait_neg("w", 2);
      tick();
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(posedge clk);
         done = (exp_s_q.size() == 0) && (exp_r_q.size() == 0) && (exp_b_q.size() == 0);
      end
      #1;
      if (!done) begin
         n_checks++;
         n_fails++;
         $display("FAIL drain_timeout: got s=%0d r=%0d b=%0d pending expected 0",
                  exp_s_q.size(), exp_r_q.size(), exp_b_q.size());
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before 500000 time units");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   logic [31:0] wr_tab [4] = '{32'h01234567, 32'h89ABCDEF, 32'h0BADF00D, 32'hCAFEBABE};

   initial begin
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0;
      arprot = 0; arvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
      awlock = 0; awcache = 0; awprot = 0; awvalid = 0; wid = 0; wdata = 0; wstrb = 0;
      wlast = 0; wvalid = 0; rready = 1; bready = 1;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[32'h100 >> 2] = 32'hDEADBEEF;
      mem[32'h30 >> 2]  = 32'hC0DE0030;
      mem[32'h34 >> 2]  = 32'hC0DE0034;
      mem[32'h38 >> 2]  = 32'hC0DE0038;
      mem[32'h3C >> 2]  = 32'hC0DE003C;
      mem[32'h400 >> 2] = 32'h11223344;

      // Reset state
      rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_arready", arready, 0);
      check("rst_awready", awready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_sram_en", {sram_en, sram_write_en}, 0);
      check("rst_rchan", {rdata, rid, rresp}, 0);
      check("rst_bchan", {bid, bresp}, 0);
      tick();
      rst = 1'b1;
      tick();

      // Single read
      exp_s_q.push_back({4'h0, 32'h100, 32'h0});
      exp_r_q.push_back({4'h5, 32'hDEADBEEF, RESP_OKAY, 1'b1});
      send_ar(4'h5, 32'h100, 8'd0, SIZE_4B, BURST_INCR);
      wait_drain();

      // INCR write, 4 beats
      for (int i = 0; i < 4; i++)
         exp_s_q.push_back({4'hF, 32'h200 + 32'(4 * i), wr_tab[i]});
      exp_b_q.push_back({4'hA, RESP_OKAY});
      send_aw(4'hA, 32'h200, 8'd3, SIZE_4B, BURST_INCR);
      for (int i = 0; i < 4; i++) send_w(wr_tab[i], 4'hF, i == 3);
      wait_drain();

      // Read back two of the written words
      exp_s_q.push_back({4'h0, 32'h204, 32'h0});
      exp_s_q.push_back({4'h0, 32'h208, 32'h0});
      exp_r_q.push_back({4'h6, 32'h89ABCDEF, RESP_OKAY, 1'b0});
      exp_r_q.push_back({4'h6, 32'h0BADF00D, RESP_OKAY, 1'b1});
      send_ar(4'h6, 32'h204, 8'd1, SIZE_4B, BURST_INCR);
      wait_drain();

      // WRAP read: 0x38, 0x3C, 0x30, 0x34
      exp_s_q.push_back({4'h0, 32'h38, 32'h0});
      exp_s_q.push_back({4'h0, 32'h3C, 32'h0});
      exp_s_q.push_back({4'h0, 32'h30, 32'h0});
      exp_s_q.push_back({4'h0, 32'h34, 32'h0});
      exp_r_q.push_back({4'h9, 32'hC0DE0038, RESP_OKAY, 1'b0});
      exp_r_q.push_back({4'h9, 32'hC0DE003C, RESP_OKAY, 1'b0});
      exp_r_q.push_back({4'h9, 32'hC0DE0030, RESP_OKAY, 1'b0});
      exp_r_q.push_back({4'h9, 32'hC0DE0034, RESP_OKAY, 1'b1});
      send_ar(4'h9, 32'h38, 8'd3, SIZE_4B, BURST_WRAP);
      wait_drain();

      // Byte write to 0x403 then read the word back
      exp_s_q.push_back({4'b1000, 32'h400, 32'hABFFFFFF});
      exp_b_q.push_back({4'h2, RESP_OKAY});
      send_aw(4'h2, 32'h403, 8'd0, SIZE_1B, BURST_INCR);
      send_w(32'hABFFFFFF, 4'b1000, 1'b1);
      wait_drain();
      exp_s_q.push_back({4'h0, 32'h400, 32'h0});
      exp_r_q.push_back({4'h2, 32'hAB223344, RESP_OKAY, 1'b1});
      send_ar(4'h2, 32'h400, 8'd0, SIZE_4B, BURST_INCR);
      wait_drain();

      // Error read: reserved burst type, 2 beats, no SRAM access
      exp_r_q.push_back({4'h3, 32'h0, RESP_SLVERR, 1'b0});
      exp_r_q.push_back({4'h3, 32'h0, RESP_SLVERR, 1'b1});
      send_ar(4'h3, 32'h100, 8'd1, SIZE_4B, BURST_RSVD);
      wait_drain();

      // Error write: WRAP of 3 beats, all beats taken, no SRAM access
      exp_b_q.push_back({4'h4, RESP_SLVERR});
      send_aw(4'h4, 32'h10, 8'd2, SIZE_4B, BURST_WRAP);
      for (int i = 0; i < 3; i++) send_w(32'hFFFF0000 + 32'(i), 4'hF, i == 2);
      wait_drain();

      // Reset during beat 2 of a 4-beat write
      exp_s_q.push_back({4'hF, 32'h500, 32'h77770000});
      send_aw(4'h7, 32'h500, 8'd3, SIZE_4B, BURST_INCR);
      send_w(32'h77770000, 4'hF, 1'b0);
      wdata = 32'h77770001; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_sram_en", sram_en, 0);
      tick();
      wvalid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_valids", {rvalid, bvalid, wready, sram_en}, 0);
      check("post_rst_readys", {arready, awready}, 0);
      tick();

      // Contention: read first after reset, then write; rready stalled
      rready = 1'b0;
      exp_s_q.push_back({4'h0, 32'h100, 32'h0});
      exp_r_q.push_back({4'h1, 32'hDEADBEEF, RESP_OKAY, 1'b1});
      exp_s_q.push_back({4'hF, 32'h600, 32'h5555AAAA});
      exp_b_q.push_back({4'h2, RESP_OKAY});
      exp_s_q.push_back({4'h0, 32'h600, 32'h0});
      exp_r_q.push_back({4'h4, 32'h5555AAAA, RESP_OKAY, 1'b1});
      arid = 4'h1; araddr = 32'h100; arlen = 8'd0; arsize = SIZE_4B; arburst = BURST_INCR;
      awid = 4'h2; awaddr = 32'h600; awlen = 8'd0; awsize = SIZE_4B; awburst = BURST_INCR;
      arvalid = 1'b1;
      awvalid = 1'b1;
      @(negedge clk);
      check("contend1_grant", {arready, awready}, 2'b10);
      tick();
      arvalid = 1'b0;
      wait_neg("rvalid", 3);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("stall_rvalid", rvalid, 1);
         check("stall_rdata", rdata, 32'hDEADBEEF);
      end
      tick();
      arid = 4'h4; araddr = 32'h600; arvalid = 1'b1;
      rready = 1'b1;
      wait_neg("contend2", 1);
      check("contend2_grant", {arready, awready}, 2'b01);
      tick();
      awvalid = 1'b0;
      send_w(32'h5555AAAA, 4'hF, 1'b1);
      wait_neg("ar_pending", 0);
      tick();
      arvalid = 1'b0;
      wait_drain();

      check("end_s_queue", 32'(exp_s_q.size()), 0);
      check("end_r_queue", 32'(exp_r_q.size()), 0);
      check("end_b_queue", 32'(exp_b_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
